// File: rtl/alu_pkg.sv
// Shared types and constants for the registered ALU slice.
// State encoding, op select bit positions and operand-control bit positions.
package alu_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'b00,
      ST_IDLE = 2'b01,
      ST_LOAD = 2'b10,
      ST_ACC  = 2'b11
   } state_t;

   localparam int OP_W   = 7;
   localparam int OP_ADD = 0;
   localparam int OP_SUB = 1;
   localparam int OP_MUL = 2;
   localparam int OP_AND = 3;
   localparam int OP_OR  = 4;
   localparam int OP_XOR = 5;
   localparam int OP_NOT = 6;

   localparam int SEL_W       = 3;
   localparam int SEL_CLR     = 0;
   localparam int SEL_LOAD    = 1;
   localparam int SEL_PERSIST = 2;

   // True when exactly one select bit is set.
   function automatic logic is_onehot(input logic [OP_W-1:0] v);
      return (v != '0) && ((v & (v - 7'd1)) == '0);
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational operation unit of the registered ALU.
// Any select that is not exactly one-hot produces zero.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  out_sel,
   output logic [WIDTH-1:0] result
);

   logic [2*WIDTH-1:0] prod;

   assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   // Select one operation; illegal selects fall through to zero.
   always_comb begin
      result = '0;
      if (is_onehot(out_sel)) begin
         unique case (1'b1)
            out_sel[OP_ADD]: result = a + b;
            out_sel[OP_SUB]: result = a - b;
            out_sel[OP_MUL]: result = prod[WIDTH-1:0];
            out_sel[OP_AND]: result = a & b;
            out_sel[OP_OR]:  result = a | b;
            out_sel[OP_XOR]: result = a ^ b;
            out_sel[OP_NOT]: result = ~a;
            default:         result = '0;
         endcase
      end
   end

endmodule

// File: rtl/alu_main.sv
// Registered ALU with operand registers and a 2-bit control FSM.
// The FSM next state also chooses which operands feed the core.
module alu_main
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             on,
   input  logic [2:0]       in_sel,
   input  logic [WIDTH-1:0] num1,
   input  logic [WIDTH-1:0] num2,
   input  logic [6:0]       out_sel,
   output logic [WIDTH-1:0] out,
   output logic [1:0]       currState,
   output logic [1:0]       nextState
);

   state_t           cur_st;
   state_t           nxt_st;
   logic [WIDTH-1:0] reg_a;
   logic [WIDTH-1:0] reg_b;
   logic [WIDTH-1:0] reg_r;
   logic [WIDTH-1:0] core_a;
   logic [WIDTH-1:0] core_b;
   logic [WIDTH-1:0] core_r;

   // Next state by action priority: rst, off, clear, load, persist, hold.
   always_comb begin
      nxt_st = ST_IDLE;
      if (rst)
         nxt_st = ST_OFF;
      else if (!on)
         nxt_st = ST_OFF;
      else if (in_sel[SEL_CLR])
         nxt_st = ST_IDLE;
      else if (in_sel[SEL_LOAD])
         nxt_st = ST_LOAD;
      else if (in_sel[SEL_PERSIST])
         nxt_st = ST_ACC;
   end

   // Operand source follows the winning action.
   always_comb begin
      core_a = reg_a;
      core_b = reg_b;
      unique case (nxt_st)
         ST_LOAD: begin
            core_a = num1;
            core_b = num2;
         end
         ST_ACC: begin
            core_a = reg_r;
            core_b = num2;
         end
         default: begin
            core_a = reg_a;
            core_b = reg_b;
         end
      endcase
   end

   alu_core #(
      .WIDTH   (WIDTH)
   ) u_core (
      .a       (core_a),
      .b       (core_b),
      .out_sel (out_sel),
      .result  (core_r)
   );

   // State, operand and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_st <= ST_OFF;
         reg_a  <= '0;
         reg_b  <= '0;
         reg_r  <= '0;
      end else begin
         cur_st <= nxt_st;
         unique case (nxt_st)
            ST_OFF: begin
               reg_r <= '0;
            end
            ST_IDLE: begin
               if (in_sel[SEL_CLR]) begin
                  reg_a <= '0;
                  reg_b <= '0;
                  reg_r <= '0;
               end else begin
                  reg_r <= core_r;
               end
            end
            ST_LOAD: begin
               reg_a <= num1;
               reg_b <= num2;
               reg_r <= core_r;
            end
            ST_ACC: begin
               reg_a <= reg_r;
               reg_b <= num2;
               reg_r <= core_r;
            end
            default: begin
               reg_r <= '0;
            end
         endcase
      end
   end

   assign out       = reg_r;
   assign currState = cur_st;
   assign nextState = nxt_st;

endmodule

// File: tb/tb_alu_main.sv
// Self-checking bench for alu_main.
// Directed scenarios plus random traffic against a behavioural model.
module tb_alu_main;

   logic       clk = 1'b0;
   logic       rst;
   logic       on;
   logic [2:0] in_sel;
   logic [7:0] num1;
   logic [7:0] num2;
   logic [6:0] out_sel;
   logic [7:0] out;
   logic [1:0] currState;
   logic [1:0] nextState;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] m_a = 8'h00;
   logic [7:0] m_b = 8'h00;
   logic [7:0] m_r = 8'h00;
   logic [1:0] m_st = 2'b00;

   always #5 clk = ~clk;

   alu_main #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .on        (on),
      .in_sel    (in_sel),
      .num1      (num1),
      .num2      (num2),
      .out_sel   (out_sel),
      .out       (out),
      .currState (currState),
      .nextState (nextState)
   );

   function automatic logic [7:0] ref_op(input logic [6:0] os,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
      int x, y;
      x = a;
      y = b;
      if ($countones(os) != 1) return 8'h00;
      if (os[0]) return 8'((x + y) % 256);
      if (os[1]) return 8'((x - y + 256) % 256);
      if (os[2]) return 8'((x * y) % 256);
      if (os[3]) return a & b;
      if (os[4]) return a | b;
      if (os[5]) return a ^ b;
      return 8'(255 - x);
   endfunction

   function automatic logic [1:0] ref_next(input logic r, input logic o,
                                           input logic [2:0] s);
      if (r) return 2'd0;
      if (!o) return 2'd0;
      if (s[0]) return 2'd1;
      if (s[1]) return 2'd2;
      if (s[2]) return 2'd3;
      return 2'd1;
   endfunction

   task automatic drive(input logic r, input logic o, input logic [2:0] s,
                        input logic [7:0] n1, input logic [7:0] n2,
                        input logic [6:0] os);
      rst = r;
      on = o;
      in_sel = s;
      num1 = n1;
      num2 = n2;
      out_sel = os;
   endtask

   // Advance one edge and apply the same action to the model.
   task automatic tick();
      logic [7:0] nr;
      @(posedge clk);
      m_st = ref_next(rst, on, in_sel);
      if (rst) begin
         m_a = 0; m_b = 0; m_r = 0;
      end else if (!on) begin
         m_r = 0;
      end else if (in_sel[0]) begin
         m_a = 0; m_b = 0; m_r = 0;
      end else if (in_sel[1]) begin
         m_a = num1; m_b = num2; m_r = ref_op(out_sel, num1, num2);
      end else if (in_sel[2]) begin
         nr = ref_op(out_sel, m_r, num2);
         m_a = m_r; m_b = num2; m_r = nr;
      end else begin
         m_r = ref_op(out_sel, m_a, m_b);
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'($urandom), 3'($urandom), 8'($urandom),
               8'($urandom), 7'($urandom));
         #1;
         vectors++;
         if (nextState !== 2'b00) begin
            $display("FAIL reset_next got=%b exp=00", nextState);
            miscompares++;
         end
         tick();
      end
      vectors++;
      if (out !== 8'h00) begin
         $display("FAIL reset_out got=%h exp=00", out);
         miscompares++;
      end
      vectors++;
      if (currState !== 2'b00) begin
         $display("FAIL reset_state got=%b exp=00", currState);
         miscompares++;
      end
      drive(1'b0, 1'b1, 3'b000, 8'h00, 8'h00, 7'b0000001);
      tick();
      vectors++;
      if (currState !== 2'b01) begin
         $display("FAIL reset_idle got=%b exp=01", currState);
         miscompares++;
      end
   endtask

   task automatic test_load_hold();
      drive(1'b0, 1'b1, 3'b010, 8'h57, 8'h1A, 7'b0001000);
      tick();
      vectors++;
      if (out !== 8'h12 || currState !== 2'b10) begin
         $display("FAIL load_and got=%h/%b exp=12/10", out, currState);
         miscompares++;
      end
      drive(1'b0, 1'b1, 3'b000, 8'h00, 8'h01, 7'b0000010);
      tick();
      vectors++;
      if (out !== 8'h3D || currState !== 2'b01) begin
         $display("FAIL hold_sub got=%h/%b exp=3d/01", out, currState);
         miscompares++;
      end
   endtask

   task automatic test_persist_chain();
      logic [7:0] exp [3];
      exp = '{8'h10, 8'h15, 8'h1A};
      drive(1'b0, 1'b1, 3'b010, 8'hF0, 8'h20, 7'b0000001);
      tick();
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (out !== exp[i] || out !== m_r) begin
            $display("FAIL persist_%0d got=%h exp=%h", i, out, exp[i]);
            miscompares++;
         end
         drive(1'b0, 1'b1, 3'b100, 8'hEE, 8'h05, 7'b0000001);
         if (i < 2) tick();
      end
      vectors++;
      if (currState !== 2'b11) begin
         $display("FAIL persist_state got=%b exp=11", currState);
         miscompares++;
      end
   endtask

   task automatic test_op_sweep();
      logic [7:0] exp [7];
      logic [6:0] os;
      exp = '{8'h16, 8'h02, 8'h78, 8'h08, 8'h0E, 8'h06, 8'hF3};
      for (int i = 0; i < 7; i++) begin
         os = 7'(1 << i);
         drive(1'b0, 1'b1, 3'b010, 8'h0C, 8'h0A, os);
         tick();
         vectors++;
         if (out !== exp[i]) begin
            $display("FAIL sweep_load_op%0d got=%h exp=%h", i, out, exp[i]);
            miscompares++;
         end
         drive(1'b0, 1'b1, 3'b000, 8'h77, 8'h99, os);
         tick();
         vectors++;
         if (out !== exp[i]) begin
            $display("FAIL sweep_hold_op%0d got=%h exp=%h", i, out, exp[i]);
            miscompares++;
         end
      end
      drive(1'b0, 1'b1, 3'b000, 8'h00, 8'h00, 7'b0000011);
      tick();
      vectors++;
      if (out !== 8'h00) begin
         $display("FAIL sweep_multi got=%h exp=00", out);
         miscompares++;
      end
      drive(1'b0, 1'b1, 3'b000, 8'h00, 8'h00, 7'b0000000);
      tick();
      vectors++;
      if (out !== 8'h00) begin
         $display("FAIL sweep_zero got=%h exp=00", out);
         miscompares++;
      end
   endtask

   task automatic test_priority_off();
      drive(1'b0, 1'b1, 3'b010, 8'h33, 8'h11, 7'b0000001);
      tick();
      drive(1'b0, 1'b1, 3'b111, 8'h44, 8'h55, 7'b0000001);
      tick();
      vectors++;
      if (out !== 8'h00 || currState !== 2'b01) begin
         $display("FAIL prio_clear got=%h/%b exp=00/01", out, currState);
         miscompares++;
      end
      drive(1'b0, 1'b1, 3'b010, 8'h33, 8'h11, 7'b0000001);
      tick();
      drive(1'b0, 1'b0, 3'b010, 8'hFF, 8'hFF, 7'b0000001);
      #1;
      vectors++;
      if (nextState !== 2'b00) begin
         $display("FAIL off_next got=%b exp=00", nextState);
         miscompares++;
      end
      tick();
      vectors++;
      if (out !== 8'h00 || currState !== 2'b00) begin
         $display("FAIL off_state got=%h/%b exp=00/00", out, currState);
         miscompares++;
      end
      drive(1'b0, 1'b1, 3'b000, 8'hFF, 8'hFF, 7'b0000001);
      tick();
      vectors++;
      if (out !== 8'h44 || currState !== 2'b01) begin
         $display("FAIL off_resume got=%h/%b exp=44/01", out, currState);
         miscompares++;
      end
   endtask

   task automatic test_random();
      logic [6:0] os;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(3) == 0)
            os = 7'($urandom);
         else
            os = 7'(1 << $urandom_range(6));
         drive(1'($urandom_range(29) == 0), 1'($urandom_range(9) != 0),
               3'($urandom), 8'($urandom), 8'($urandom), os);
         if ($urandom_range(2) == 0) in_sel = 3'b000;
         #1;
         vectors++;
         if (nextState !== ref_next(rst, on, in_sel)) begin
            $display("FAIL rand_next_%0d got=%b exp=%b", i, nextState,
                     ref_next(rst, on, in_sel));
            miscompares++;
         end
         tick();
         vectors++;
         if (out !== m_r || currState !== m_st) begin
            $display("FAIL rand_%0d got=%h/%b exp=%h/%b", i, out, currState,
                     m_r, m_st);
            miscompares++;
         end
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 1'b1, 3'b010, 8'h21, 8'h03, 7'b0000100);
      tick();
      drive(1'b1, 1'b1, 3'b100, 8'h21, 8'h03, 7'b0000100);
      tick();
      vectors++;
      if (out !== 8'h00 || currState !== 2'b00) begin
         $display("FAIL reset_mid got=%h/%b exp=00/00", out, currState);
         miscompares++;
      end
      drive(1'b0, 1'b1, 3'b000, 8'h21, 8'h03, 7'b0010000);
      tick();
      vectors++;
      if (out !== 8'h00) begin
         $display("FAIL reset_mid_hold got=%h exp=00", out);
         miscompares++;
      end
   endtask

   initial begin
      drive(1'b1, 1'b0, 3'b000, 8'h00, 8'h00, 7'b0000000);
      @(negedge clk);
      test_reset();
      test_load_hold();
      test_persist_chain();
      test_op_sweep();
      test_priority_off();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors,
               miscompares);
      $finish;
   end

endmodule

// File: doc/alu_main.md
Name: alu_main

Overview:
- 8-bit registered ALU with an operand-holding datapath and a 2-bit control state machine.
- Operands are loaded from `num1`/`num2`, held, cleared, or chained with the previous result (persist), under control of `in_sel`.
- The operation is chosen by one-hot `out_sel`; the registered result drives `out`.
- `currState` and `nextState` are exported for observation.

Parameters:
- WIDTH, 8, data width of `num1`, `num2`, `out` and the internal operand registers.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous reset, active-high
- on  input  1  enable; 0 forces the OFF state
- in_sel  input  3  operand control: [2]=persist, [1]=load, [0]=clear
- num1  input  WIDTH  operand A source
- num2  input  WIDTH  operand B source
- out_sel  input  7  one-hot operation select
- out  output  WIDTH  registered ALU result
- currState  output  2  registered FSM state
- nextState  output  2  combinational next state

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Internal registers: A, B (operands), R (result, drives `out`).
- State encoding: OFF=2'b00, IDLE=2'b01, LOAD=2'b10, ACC=2'b11.
- Action priority on each rising edge is rst > !on > in_sel[0] > in_sel[1] > in_sel[2] > hold. Only the highest-priority asserted action takes effect.
- rst=1: A=B=R=0; currState=OFF. `nextState` reports OFF while rst=1.
- on=0: currState<=OFF; A and B hold; R<=0.
- clear (in_sel[0]): A<=0, B<=0, R<=0; state IDLE.
- load (in_sel[1]): A<=num1, B<=num2, R<=op(num1,num2); state LOAD. The result is visible on `out` one cycle after the load edge.
- persist (in_sel[2]): A<=R, B<=num2, R<=op(R,num2); state ACC. This chains computations.
- hold (in_sel=000, on=1): A and B hold; R<=op(A,B) with the current `out_sel`; state IDLE. `num1`/`num2` are ignored.
- Operations on `out_sel` (results are modulo 2^WIDTH; no carry or flag outputs):
  - bit0 ADD: A+B
  - bit1 SUB: A−B, two's complement wrap
  - bit2 MUL: low WIDTH bits of A*B
  - bit3 AND
  - bit4 OR
  - bit5 XOR
  - bit6 NOT A
- `out_sel` equal to zero or with more than one bit set yields R<=0.
- `nextState` is the combinational function of rst, on and in_sel given above. `currState` is `nextState` registered.
- Reset mid-operation discards all pending results.

Decomposition:
- Shared package `alu_pkg` holds:
  - state enum (OFF/IDLE/LOAD/ACC with the encodings above)
  - op bit-index constants OP_ADD=0 … OP_NOT=6
  - in_sel bit-index constants SEL_CLR=0, SEL_LOAD=1, SEL_PERSIST=2
- One combinational sub-module `alu_core`: inputs a, b, out_sel; output result, including the non-one-hot → 0 rule.
- The top level holds the FSM and the A/B/R registers.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs → out=0x00, currState=2'b00; after rst=0, on=1, in_sel=000 → currState=2'b01.
- Load AND: in_sel=010, num1=0x57, num2=0x1A, out_sel=0001000 → next cycle out=0x12, currState=2'b10.
- Hold SUB: following the previous case, in_sel=000, num1=0x00, num2=0x01, out_sel=0000010 → out=0x3D (0x57−0x1A; inputs ignored), currState=2'b01.
- Persist ADD chain: load 0xF0/0x20 with ADD → out=0x10 (wrap); then in_sel=100, num2=0x05 → out=0x15, then 0x1A, currState=2'b11.
- Op sweep with A=0x0C, B=0x0A:
  - ADD=0x16, SUB=0x02, MUL=0x78, AND=0x08, OR=0x0E, XOR=0x06, NOT=0xF3
  - out_sel=0000011 → 0x00
- Priority/off: in_sel=111 → clear wins (out=0, currState=01); on=0 with in_sel=010 → currState=00, out=0, A/B unchanged; after on=1 with hold+ADD → out=op of the old A/B.
